// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, flag
// bit positions, BHT counter reset value and the condition evaluator.
package branch_resolve_unit_pkg;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] BHT_RESET = 2'b01;

  function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
    logic n, z, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    v = f[FLAG_V];
    case (cc)
      CC_NEQ:  return !z;
      CC_EQ:   return z;
      CC_GT:   return !z && !n;
      CC_LT:   return n;
      CC_GTE:  return z || !n;
      CC_LTE:  return n || z;
      CC_OVFL: return v;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_bimodal.sv
// Bimodal branch history table: 2-bit saturating counters indexed by pc[IDX_W:1],
// combinational read port, one saturating update per cycle.
module bht_bimodal
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_taken,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;

  assign rd_idx  = rd_pc[IDX_W:1];
  assign upd_idx = upd_pc[IDX_W:1];

  // Reads see the pre-update value when indices collide; there is no bypass.
  assign rd_taken = ctr[rd_idx][1];

  // NOTE: the array is reset in full because predictions must start weakly
  // not-taken; this forces flops rather than a RAM macro, which is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_RESET;
    end else if (upd_en) begin
      if (upd_taken && ctr[upd_idx] != 2'b11)
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      else if (!upd_taken && ctr[upd_idx] != 2'b00)
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: N/Z/V flag register with same-cycle bypass, condition
// evaluation, bimodal BHT and registered branch resolution.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BHT_DEPTH = 16,
  parameter int PC_INC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        flag_wr_en,
  input  logic [2:0]        flag_in,
  output logic [2:0]        flags,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_pred_taken,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [ADDR_W-1:0] res_redirect_pc
);

  logic [2:0]        eff;
  logic              cond;
  logic [ADDR_W-1:0] next_pc;

  // A same-cycle ALU write reaches the branch without waiting for the register.
  assign eff  = (flag_wr_en & flag_in) | (~flag_wr_en & flags);
  assign cond = cond_eval(br_cond, eff);

  // NOTE: the fall-through default is assigned before the override so every
  // path writes next_pc and no latch is inferred.
  always_comb begin
    next_pc = br_pc + ADDR_W'(PC_INC);
    if (cond) next_pc = br_target;
  end

  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++)
        if (flag_wr_en[i]) flags[i] <= flag_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_redirect_pc <= '0;
    end else begin
      res_valid      <= br_valid;
      res_taken      <= br_valid && cond;
      res_mispredict <= br_valid && (cond ^ br_pred_taken);
      if (br_valid) res_redirect_pc <= next_pc;
    end
  end

  bht_bimodal #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BHT_DEPTH)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc),
    .rd_taken  (fetch_pred_taken),
    .upd_en    (br_valid && (br_cond != CC_UNCOND)),
    .upd_pc    (br_pc),
    .upd_taken (cond)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default 16-entry instance and a
// 4-entry instance (for aliasing) share all stimulus.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  flag_wr_en;
  logic [2:0]  flag_in;
  logic [15:0] fetch_pc;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc;
  logic [15:0] br_target;
  logic        br_pred_taken;

  logic [2:0]  flags, flags4;
  logic        fetch_pred_taken, fetch_pred_taken4;
  logic        res_valid, res_valid4;
  logic        res_taken, res_taken4;
  logic        res_mispredict, res_mispredict4;
  logic [15:0] res_redirect_pc, res_redirect_pc4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .flag_wr_en       (flag_wr_en),
    .flag_in          (flag_in),
    .flags            (flags),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken),
    .br_valid         (br_valid),
    .br_cond          (br_cond),
    .br_pc            (br_pc),
    .br_target        (br_target),
    .br_pred_taken    (br_pred_taken),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_mispredict   (res_mispredict),
    .res_redirect_pc  (res_redirect_pc)
  );

  branch_resolve_unit #(.BHT_DEPTH(4)) dut4 (
    .clk              (clk),
    .rst              (rst),
    .flag_wr_en       (flag_wr_en),
    .flag_in          (flag_in),
    .flags            (flags4),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken4),
    .br_valid         (br_valid),
    .br_cond          (br_cond),
    .br_pc            (br_pc),
    .br_target        (br_target),
    .br_pred_taken    (br_pred_taken),
    .res_valid        (res_valid4),
    .res_taken        (res_taken4),
    .res_mispredict   (res_mispredict4),
    .res_redirect_pc  (res_redirect_pc4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_flags(input logic [2:0] wen, input logic [2:0] val);
    flag_wr_en = wen;
    flag_in    = val;
    @(posedge clk); #1;
    flag_wr_en = 3'b000;
  endtask

  task automatic do_branch(input logic [2:0] cc, input logic [15:0] pc,
                           input logic [15:0] tgt, input logic pred);
    br_valid      = 1'b1;
    br_cond       = cc;
    br_pc         = pc;
    br_target     = tgt;
    br_pred_taken = pred;
    @(posedge clk); #1;
    br_valid = 1'b0;
  endtask

  function automatic logic exp_cond(input logic [2:0] cc, input logic [2:0] f);
    case (cc)
      3'd0: return ~f[1];
      3'd1: return f[1];
      3'd2: return ~f[1] & ~f[2];
      3'd3: return f[2];
      3'd4: return f[1] | ~f[2];
      3'd5: return f[2] | f[1];
      3'd6: return f[0];
      default: return 1'b1;
    endcase
  endfunction

  logic exp_up [4];
  logic exp_dn [4];
  logic e;

  initial begin
    exp_up = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    flag_wr_en = 3'b000; flag_in = 3'b000;
    fetch_pc = 16'h0004;
    br_valid = 1'b0; br_cond = 3'b000; br_pc = '0; br_target = '0; br_pred_taken = 1'b0;

    // 1: reset state, then reset during an in-flight resolution
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", flags, 3'b000);
    check("rst_res_valid", res_valid, 0);
    check("rst_redirect", res_redirect_pc, 16'h0000);
    rst = 1'b0;
    #1;
    check("rel_fetch_pred", fetch_pred_taken, 0);
    do_branch(CC_UNCOND, 16'h0030, 16'h0050, 1'b0);
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_redirect", res_redirect_pc, 16'h0050);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", res_valid, 0);
    check("midrst_taken", res_taken, 0);
    check("midrst_mispred", res_mispredict, 0);
    check("midrst_redirect", res_redirect_pc, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2: flag write bypassed to a same-cycle EQ branch
    flag_wr_en = 3'b010; flag_in = 3'b010;
    do_branch(CC_EQ, 16'h0010, 16'h0040, 1'b0);
    flag_wr_en = 3'b000;
    check("byp_valid", res_valid, 1);
    check("byp_taken", res_taken, 1);
    check("byp_mispred", res_mispredict, 1);
    check("byp_redirect", res_redirect_pc, 16'h0040);
    check("byp_flags", flags, 3'b010);
    @(posedge clk); #1;
    check("idle_valid", res_valid, 0);
    check("idle_taken", res_taken, 0);
    check("idle_mispred", res_mispredict, 0);
    check("idle_redirect_hold", res_redirect_pc, 16'h0040);

    // partial write: only N written, Z must hold
    write_flags(3'b100, 3'b101);
    check("partial_flags", flags, 3'b110);

    // 3: all condition codes against all flag combinations
    for (int f = 0; f < 8; f++) begin
      write_flags(3'b111, 3'(f));
      check($sformatf("sweep_flags f=%0d", f), flags, 32'(f));
      for (int c = 0; c < 8; c++) begin
        do_branch(3'(c), 16'h0020, 16'h0100, 1'b0);
        e = exp_cond(3'(c), 3'(f));
        check($sformatf("sweep_taken f=%0d cc=%0d", f, c), res_taken, 32'(e));
        check($sformatf("sweep_redir f=%0d cc=%0d", f, c), res_redirect_pc,
              e ? 32'h0100 : 32'h0022);
      end
    end

    // 4: saturating counter walk at pc 0x0008
    fetch_pc = 16'h0008;
    write_flags(3'b111, 3'b000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("up_pred_before%0d", i), fetch_pred_taken, 32'(exp_up[i]));
      do_branch(CC_NEQ, 16'h0008, 16'h0080, 1'b1);
      check($sformatf("up_mispred%0d", i), res_mispredict, 0);
    end
    check("up_pred_sat", fetch_pred_taken, 1);
    write_flags(3'b111, 3'b010);
    for (int i = 0; i < 4; i++) begin
      do_branch(CC_NEQ, 16'h0008, 16'h0080, 1'b1);
      check($sformatf("dn_taken%0d", i), res_taken, 0);
      check($sformatf("dn_pred_after%0d", i), fetch_pred_taken, 32'(exp_dn[i]));
    end
    check("dn_redirect", res_redirect_pc, 16'h000A);
    write_flags(3'b111, 3'b000);
    do_branch(CC_NEQ, 16'h0008, 16'h0080, 1'b0);
    check("floor_pred1", fetch_pred_taken, 0);
    do_branch(CC_NEQ, 16'h0008, 16'h0080, 1'b0);
    check("floor_pred2", fetch_pred_taken, 1);

    // 5: unconditional branches leave the BHT alone; fall-through wraps
    fetch_pc = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      do_branch(CC_UNCOND, 16'h0006, 16'h0200, 1'b0);
      check($sformatf("unc_taken%0d", i), res_taken, 1);
      check($sformatf("unc_redirect%0d", i), res_redirect_pc, 16'h0200);
      check($sformatf("unc_pred%0d", i), fetch_pred_taken, 0);
    end
    write_flags(3'b111, 3'b010);
    do_branch(CC_NEQ, 16'hFFFE, 16'h1234, 1'b1);
    check("wrap_taken", res_taken, 0);
    check("wrap_mispred", res_mispredict, 1);
    check("wrap_redirect", res_redirect_pc, 16'h0000);

    // 6: aliasing in the 4-entry table and no read bypass
    write_flags(3'b111, 3'b000);
    fetch_pc = 16'h0002;
    #1;
    check("alias_pred_init", fetch_pred_taken4, 0);
    br_valid = 1'b1; br_cond = CC_NEQ; br_pc = 16'h0002;
    br_target = 16'h0300; br_pred_taken = 1'b0;
    #1;
    check("same_cycle_old", fetch_pred_taken4, 0);
    @(posedge clk); #1;
    br_valid = 1'b0;
    check("next_cycle_new", fetch_pred_taken4, 1);
    check("d16_after_taken", fetch_pred_taken, 1);
    write_flags(3'b111, 3'b010);
    do_branch(CC_NEQ, 16'h000A, 16'h0300, 1'b1);
    check("alias_pred_dn", fetch_pred_taken4, 0);
    check("d16_no_alias", fetch_pred_taken, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Next-generation branch block for the pipelined core. It holds the architectural N/Z/V flag register with per-flag write enables and same-cycle bypass, and evaluates the 3-bit condition code against the bypassed flags. A parametrised bimodal branch history table (BHT) of 2-bit saturating counters supplies fetch-time predictions. Resolved outcome, mispredict and redirect PC are registered one cycle after the branch is presented.

Parameters:
ADDR_W, 16, PC and target width in bits
BHT_DEPTH, 16, number of BHT entries (power of two, >=2); IDX_W = log2(BHT_DEPTH)
PC_INC, 2, fall-through increment added to br_pc

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flag_wr_en  input  3  per-flag write enable {N,Z,V}
flag_in  input  3  new flag values {N,Z,V} from ALU
flags  output  3  architectural flag register {N,Z,V}
fetch_pc  input  ADDR_W  PC being fetched
fetch_pred_taken  output  1  combinational prediction for fetch_pc
br_valid  input  1  branch present this cycle
br_cond  input  3  condition code ccc
br_pc  input  ADDR_W  PC of branch
br_target  input  ADDR_W  computed branch target
br_pred_taken  input  1  prediction carried down the pipe with the branch
res_valid  output  1  registered: resolution valid
res_taken  output  1  registered: branch taken
res_mispredict  output  1  registered: res_taken != br_pred_taken
res_redirect_pc  output  ADDR_W  registered: correct next PC

Behaviour:
- Reset (async, immediate): flags=3'b000; every BHT counter=2'b01 (weakly not-taken); res_valid, res_taken, res_mispredict = 0; res_redirect_pc = 0. A reset asserted mid-operation discards any in-flight resolution. The first edge after deassert behaves normally.
- Flag register: on each rising edge, bit i loads flag_in[i] if flag_wr_en[i]; otherwise it holds.
- Effective flags: eff[i] = flag_wr_en[i] ? flag_in[i] : flags[i]. A same-cycle ALU write is bypassed to the branch, so no stall is needed.
- Condition codes on eff (N=bit2, Z=bit1, V=bit0):
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Resolution, latency 1 cycle. On the edge where br_valid=1:
  - res_valid <= 1
  - res_taken <= cond
  - res_mispredict <= cond ^ br_pred_taken
  - res_redirect_pc <= cond ? br_target : br_pc + PC_INC (mod 2^ADDR_W, wraps)
- When br_valid=0, res_valid, res_taken and res_mispredict <= 0, and res_redirect_pc holds.
- BHT index = pc[IDX_W:1], i.e. bit 0 is ignored.
- fetch_pred_taken = counter[fetch_idx][1], purely combinational.
- BHT update happens on an edge with br_valid=1 and br_cond != 111:
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
- UNCOND branches never update the BHT.
- A fetch lookup to the same index being updated this cycle returns the pre-update value (no bypass).

Decomposition:
- Shared package holds the condition-code localparams (CC_NEQ..CC_UNCOND), the flag bit positions (FLAG_N=2, FLAG_Z=1, FLAG_V=0), and the BHT counter reset value 2'b01.
- One sub-module, bht_bimodal, contains the counter array, read port and saturating update. Flag register, bypass, condition evaluation and output registers stay in the top.

Test Plan:
1. Reset, release, fetch_pc=0x0004 -> fetch_pred_taken=0 and flags=000. Drive rst high mid-resolution -> all res_* outputs go 0 immediately.
2. flags=000, same cycle flag_wr_en=010 and flag_in=010, br_cond=001, br_pc=0x0010, br_target=0x0040, br_pred_taken=0 -> next cycle res_taken=1, res_mispredict=1, res_redirect_pc=0x0040, and flags=010.
3. Sweep all 8 ccc values against all 8 eff combinations (no writes), br_pc=0x0020, br_target=0x0100 -> res_taken matches the condition table; redirect is 0x0100 or 0x0022 accordingly.
4. Four taken resolutions with br_pc=0x0008, br_cond=000, Z=0 -> fetch_pred_taken at fetch_pc=0x0008 goes 0,1,1,1 and the counter saturates at 11. Four not-taken resolutions (Z=1) -> counter walks 11, 10, 01, 00 and saturates at 00.
5. br_cond=111 repeated with br_pc=0x0006 -> res_taken=1 every time, and the BHT entry stays at 01. br_pc=0xFFFE, not taken -> res_redirect_pc=0x0000 (wrap).
6. BHT_DEPTH=4: updates at br_pc=0x0002 and 0x000A alias to the same entry. Same-cycle fetch_pc=0x0002 during an update -> old value returned, and the new value is seen next cycle.
